// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave backed by a DATA_W-wide word memory: one outstanding burst per direction,
// byte-strobed writes, optional wready throttling, read data registered one cycle after AR/R handshake.
module axi_burst_slave_mem #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                MEM_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 'h1000_0000,
  parameter int                WREADY_GAP = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);

  localparam int                STRB_W      = DATA_W / 8;
  localparam int                SH          = $clog2(STRB_W);
  localparam int                IDX_W       = $clog2(MEM_WORDS);
  localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(STRB_W);
  localparam logic [1:0]        BURST_FIXED = 2'b00;
  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [3:0]        GAP         = 4'(WREADY_GAP);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Addresses below BASE_ADDR wrap to huge offsets and therefore fail the upper-bits test.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (SH + IDX_W)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> SH);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [1:0]        burst);
    return (burst == BURST_FIXED) ? a : a + BEAT_BYTES;
  endfunction

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  w_state_t          w_state, w_state_nxt;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len, w_beat;
  logic [1:0]        w_burst;
  logic              w_err;
  logic [3:0]        gap_cnt, gap_nxt;
  logic              aw_hs, w_hs, b_hs, w_done, w_beat_err;

  assign aw_hs      = s_axi_awready & s_axi_awvalid;
  assign w_hs       = s_axi_wready & s_axi_wvalid;
  assign b_hs       = s_axi_bvalid & s_axi_bready;
  assign w_done     = (w_beat == w_len);
  assign w_beat_err = !in_range(w_addr) || (s_axi_wlast != w_done);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    gap_nxt     = '0;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_done) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
    if (w_hs)              gap_nxt = GAP;
    else if (gap_cnt != 0) gap_nxt = gap_cnt - 4'd1;
  end

  // Handshake outputs are registered from the next state so reset drives them all low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_addr        <= '0;
      w_len         <= '0;
      w_burst       <= '0;
      w_beat        <= '0;
      w_err         <= 1'b0;
      gap_cnt       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      gap_cnt       <= gap_nxt;
      s_axi_awready <= (w_state_nxt == W_IDLE);
      s_axi_wready  <= (w_state_nxt == W_DATA) && (gap_nxt == '0);
      s_axi_bvalid  <= (w_state_nxt == W_RESP);
      if (aw_hs) begin
        w_addr  <= s_axi_awaddr;
        w_len   <= s_axi_awlen;
        w_burst <= s_axi_awburst;
        w_beat  <= '0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_addr <= next_addr(w_addr, w_burst);
        w_beat <= w_beat + 8'd1;
        w_err  <= w_err | w_beat_err;
        if (w_done) s_axi_bresp <= (w_err | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end else if (b_hs) begin
        s_axi_bresp <= RESP_OKAY;
      end
    end
  end

  // Memory contents survive reset, so the array lives in its own unreset process.
  always_ff @(posedge aclk) begin
    if (w_hs && in_range(w_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  r_state_t          r_state, r_state_nxt;
  logic [ADDR_W-1:0] r_addr, fetch_addr;
  logic [7:0]        r_len, r_beat;
  logic [1:0]        r_burst, fetch_burst;
  logic              ar_hs, r_hs, r_done, fetch;

  assign ar_hs       = s_axi_arready & s_axi_arvalid;
  assign r_hs        = s_axi_rvalid & s_axi_rready;
  assign r_done      = (r_beat == r_len);
  assign fetch       = ar_hs | (r_hs & ~r_done);
  assign fetch_addr  = (r_state == R_IDLE) ? s_axi_araddr : r_addr;
  assign fetch_burst = (r_state == R_IDLE) ? s_axi_arburst : r_burst;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && r_done) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // r_addr always points at the beat after the one currently presented on R.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_burst       <= '0;
      r_beat        <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rlast   <= 1'b0;
    end else begin
      s_axi_arready <= (r_state_nxt == R_IDLE);
      if (fetch) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= in_range(fetch_addr) ? mem[word_idx(fetch_addr)] : '0;
        s_axi_rresp  <= in_range(fetch_addr) ? RESP_OKAY : RESP_SLVERR;
        r_addr       <= next_addr(fetch_addr, fetch_burst);
      end else if (r_hs) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rdata  <= '0;
        s_axi_rresp  <= RESP_OKAY;
      end
      if (ar_hs) begin
        r_len       <= s_axi_arlen;
        r_burst     <= s_axi_arburst;
        r_beat      <= '0;
        s_axi_rlast <= (s_axi_arlen == 8'd0);
      end else if (r_hs) begin
        r_beat      <= r_done ? r_beat : r_beat + 8'd1;
        s_axi_rlast <= !r_done && ((r_beat + 8'd1) == r_len);
      end
    end
  end

endmodule
